// File: rtl/mdio_responder.sv
// MDIO (clause 22) responder.
// Oversamples the management interface with the system clock. Decodes read and
// write frames addressed to PHY_ADDR. Presents a simple register-bus handshake:
//   - reads use a one-clk request, with data returned one clk later;
//   - writes use a one-clk strobe.
module mdio_responder #(
  parameter logic [4:0] PHY_ADDR     = 5'd1,
  parameter int         PREAMBLE_MIN = 32
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        mdc,
  input  logic        mdio_in,
  output logic        mdio_out,
  output logic        mdio_oen,
  output logic [4:0]  reg_addr,
  output logic        reg_rd_en,
  input  logic [15:0] reg_rd_data,
  output logic        reg_wr_en,
  output logic [15:0] reg_wr_data,
  output logic        frame_err
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_ST    = 3'd1;
  localparam logic [2:0] S_OP    = 3'd2;
  localparam logic [2:0] S_PHYAD = 3'd3;
  localparam logic [2:0] S_REGAD = 3'd4;
  localparam logic [2:0] S_TA    = 3'd5;
  localparam logic [2:0] S_DATA  = 3'd6;
  localparam logic [2:0] S_SKIP  = 3'd7;

  localparam logic [5:0] PRE_MIN = 6'(PREAMBLE_MIN);
  localparam logic [5:0] PRE_SAT = 6'd32;

  logic        mdc_s1, mdc_s2, mdc_d;
  logic        mdio_s1, mdio_s2;
  logic        mdc_rise;
  logic        bit_in;

  logic [2:0]  state;
  logic [4:0]  bit_cnt;
  logic [5:0]  pre_cnt;
  logic        op_hi;
  logic        is_read;
  logic [4:0]  phy_sh;
  logic [3:0]  addr_sh;
  logic [15:0] shreg;
  logic        rd_cap;

  // Two-flop synchronisers for both pads plus one extra MDC stage for edge detection
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      mdc_s1  <= 1'b0;
      mdc_s2  <= 1'b0;
      mdc_d   <= 1'b0;
      mdio_s1 <= 1'b0;
      mdio_s2 <= 1'b0;
    end else begin
      mdc_s1  <= mdc;
      mdc_s2  <= mdc_s1;
      mdc_d   <= mdc_s2;
      mdio_s1 <= mdio_in;
      mdio_s2 <= mdio_s1;
    end
  end

  assign mdc_rise = mdc_s2 & ~mdc_d;
  assign bit_in   = mdio_s2;

  // Frame decoder: advances by one bit on every detected MDC rising edge
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state       <= S_IDLE;
      bit_cnt     <= 5'd0;
      pre_cnt     <= 6'd0;
      op_hi       <= 1'b0;
      is_read     <= 1'b0;
      phy_sh      <= 5'd0;
      addr_sh     <= 4'd0;
      shreg       <= 16'd0;
      rd_cap      <= 1'b0;
      mdio_out    <= 1'b0;
      mdio_oen    <= 1'b1;
      reg_addr    <= 5'd0;
      reg_rd_en   <= 1'b0;
      reg_wr_en   <= 1'b0;
      reg_wr_data <= 16'd0;
      frame_err   <= 1'b0;
    end else begin
      reg_rd_en <= 1'b0;
      reg_wr_en <= 1'b0;
      frame_err <= 1'b0;
      // Read data arrives one clk after the request; MDC is slow enough that
      // no bit edge can coincide with this capture.
      rd_cap    <= reg_rd_en;
      if (rd_cap) begin
        shreg <= reg_rd_data;
      end

      if (mdc_rise) begin
        case (state)
          S_IDLE: begin
            if (bit_in) begin
              if (pre_cnt != PRE_SAT) begin
                pre_cnt <= pre_cnt + 6'd1;
              end
            end else begin
              // A zero after a long enough preamble is the first start bit
              pre_cnt <= 6'd0;
              if (pre_cnt >= PRE_MIN) begin
                state <= S_ST;
              end
            end
          end

          S_ST: begin
            if (bit_in) begin
              state   <= S_OP;
              bit_cnt <= 5'd0;
            end else begin
              state     <= S_IDLE;
              frame_err <= 1'b1;
            end
          end

          S_OP: begin
            if (bit_cnt == 5'd0) begin
              op_hi   <= bit_in;
              bit_cnt <= 5'd1;
            end else if (op_hi != bit_in) begin
              // 10 is a read, 01 is a write
              is_read <= op_hi;
              state   <= S_PHYAD;
              bit_cnt <= 5'd0;
            end else begin
              state     <= S_IDLE;
              frame_err <= 1'b1;
            end
          end

          S_PHYAD: begin
            phy_sh <= {phy_sh[3:0], bit_in};
            if (bit_cnt == 5'd4) begin
              state   <= S_REGAD;
              bit_cnt <= 5'd0;
            end else begin
              bit_cnt <= bit_cnt + 5'd1;
            end
          end

          S_REGAD: begin
            addr_sh <= {addr_sh[2:0], bit_in};
            if (bit_cnt == 5'd4) begin
              reg_addr <= {addr_sh, bit_in};
              bit_cnt  <= 5'd0;
              if (phy_sh != PHY_ADDR) begin
                state <= S_SKIP;
              end else begin
                state     <= S_TA;
                reg_rd_en <= is_read;
              end
            end else begin
              bit_cnt <= bit_cnt + 5'd1;
            end
          end

          S_TA: begin
            if (is_read) begin
              if (bit_cnt == 5'd0) begin
                // Start driving the turnaround zero; the master samples it next edge
                mdio_oen <= 1'b0;
                mdio_out <= 1'b0;
                bit_cnt  <= 5'd1;
              end else begin
                mdio_out <= shreg[15];
                shreg    <= {shreg[14:0], 1'b0};
                state    <= S_DATA;
                bit_cnt  <= 5'd0;
              end
            end else begin
              if (bit_cnt == 5'd0) begin
                if (bit_in) begin
                  bit_cnt <= 5'd1;
                end else begin
                  state     <= S_IDLE;
                  frame_err <= 1'b1;
                end
              end else if (!bit_in) begin
                state   <= S_DATA;
                bit_cnt <= 5'd0;
              end else begin
                state     <= S_IDLE;
                frame_err <= 1'b1;
              end
            end
          end

          S_DATA: begin
            if (is_read) begin
              if (bit_cnt == 5'd15) begin
                // D0 has been sampled by the master at this edge: release the line
                mdio_oen <= 1'b1;
                mdio_out <= 1'b0;
                state    <= S_IDLE;
              end else begin
                mdio_out <= shreg[15];
                shreg    <= {shreg[14:0], 1'b0};
                bit_cnt  <= bit_cnt + 5'd1;
              end
            end else begin
              shreg <= {shreg[14:0], bit_in};
              if (bit_cnt == 5'd15) begin
                reg_wr_data <= {shreg[14:0], bit_in};
                reg_wr_en   <= 1'b1;
                state       <= S_IDLE;
              end else begin
                bit_cnt <= bit_cnt + 5'd1;
              end
            end
          end

          S_SKIP: begin
            // Let the other PHY's turnaround and data go by untouched
            if (bit_cnt == 5'd17) begin
              state   <= S_IDLE;
              pre_cnt <= 6'd0;
            end else begin
              bit_cnt <= bit_cnt + 5'd1;
            end
          end

          default: begin
            state <= S_IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_mdio_responder.sv
// Bench for mdio_responder.
// Acts as an MDIO master with a pulled-up shared line and provides a register
// file that answers reads one clk after the request.
`timescale 1ns/1ps
module tb_mdio_responder;
  localparam int HALF = 4;              // MDC half-period in clk cycles (MDC = clk/8)
  localparam int K_NONE = 0;
  localparam int K_W    = 1;
  localparam int K_R    = 2;
  localparam int K_E    = 3;

  typedef struct {
    int          kind;
    logic [4:0]  addr;
    logic [15:0] data;
  } exp_t;

  typedef struct {
    int          pre;
    logic [1:0]  st;
    logic [1:0]  op;
    logic [4:0]  phy;
    logic [4:0]  ra;
    logic [1:0]  ta;
    logic [15:0] wd;
    int          kind;
  } vec_t;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        mdc = 1'b0;
  logic        m_en = 1'b0;
  logic        m_val = 1'b1;
  logic        mdio_out, mdio_oen;
  logic [4:0]  reg_addr;
  logic        reg_rd_en, reg_wr_en, frame_err;
  logic [15:0] reg_rd_data = 16'h0000;
  logic [15:0] reg_wr_data;
  logic        mdio_line;

  int   checks = 0;
  int   errors = 0;
  int   phase = 3;
  int   oen_low_cnt = 0;
  logic contention = 1'b0;
  exp_t sb[$];

  assign mdio_line = m_en ? m_val : (mdio_oen ? 1'b1 : mdio_out);

  always #5 clk = ~clk;

  mdio_responder #(.PHY_ADDR(5'd1), .PREAMBLE_MIN(32)) dut (
    .clk(clk), .reset_n(reset_n), .mdc(mdc), .mdio_in(mdio_line),
    .mdio_out(mdio_out), .mdio_oen(mdio_oen), .reg_addr(reg_addr),
    .reg_rd_en(reg_rd_en), .reg_rd_data(reg_rd_data), .reg_wr_en(reg_wr_en),
    .reg_wr_data(reg_wr_data), .frame_err(frame_err)
  );

  function automatic logic [15:0] rd_model(input logic [4:0] a);
    return (a == 5'd2) ? 16'h1234 : {a, a, a, 1'b1};
  endfunction

  // Register file: data valid exactly one clk after the request, garbage otherwise
  always @(posedge clk) reg_rd_data <= reg_rd_en ? rd_model(reg_addr) : 16'hDEAD;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Strobe monitor: every strobe pops one expectation
  logic strobe_prev = 1'b0;
  int   kind_of;
  exp_t e_mon;
  always @(negedge clk) begin
    if (reset_n && m_en && !mdio_oen) contention = 1'b1;
    if (strobe_prev) chk("pulse_width", {29'd0, reg_wr_en, reg_rd_en, frame_err}, 32'd0);
    strobe_prev = reg_wr_en | reg_rd_en | frame_err;
    if (strobe_prev) begin
      kind_of = reg_wr_en ? K_W : (reg_rd_en ? K_R : K_E);
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_strobe: got kind %0d addr %0d required none", kind_of, reg_addr);
      end else begin
        e_mon = sb.pop_front();
        chk("strobe_kind", kind_of, e_mon.kind);
        if (e_mon.kind == K_W) begin
          chk("wr_addr", {27'd0, reg_addr}, {27'd0, e_mon.addr});
          chk("wr_data", {16'd0, reg_wr_data}, {16'd0, e_mon.data});
        end
        if (e_mon.kind == K_R) chk("rd_addr", {27'd0, reg_addr}, {27'd0, e_mon.addr});
      end
    end
  end

  // One MDC period: master drives during low phase, samples the line just before the rise
  task automatic mdc_bit(input logic v, input logic rel, output logic smp);
    mdc   = 1'b0;
    m_en  = ~rel;
    m_val = v;
    repeat (HALF) @(posedge clk);
    #(phase);
    smp = mdio_line;
    if (!mdio_oen) oen_low_cnt++;
    mdc = 1'b1;
    repeat (HALF) @(posedge clk);
    #(phase);
  endtask

  task automatic send_bits(input logic [15:0] val, input int n);
    logic s;
    for (int i = n - 1; i >= 0; i--) mdc_bit(val[i], 1'b0, s);
  endtask

  task automatic frame(input vec_t v, input string tag);
    logic        s;
    logic [17:0] rbits;
    exp_t        e;
    e.kind = v.kind;
    e.addr = v.ra;
    e.data = v.wd;
    if (v.kind != K_NONE) sb.push_back(e);
    contention  = 1'b0;
    oen_low_cnt = 0;
    rbits       = '0;
    for (int i = 0; i < v.pre; i++) mdc_bit(1'b1, 1'b0, s);
    send_bits({14'd0, v.st}, 2);
    send_bits({14'd0, v.op}, 2);
    send_bits({11'd0, v.phy}, 5);
    send_bits({11'd0, v.ra}, 5);
    if (v.op == 2'b10) begin
      for (int i = 17; i >= 0; i--) begin
        mdc_bit(1'b1, 1'b1, s);
        rbits[i] = s;
      end
    end else begin
      send_bits({14'd0, v.ta}, 2);
      send_bits(v.wd, 16);
    end
    if (v.op == 2'b10 && v.kind == K_R) begin
      chk({tag, "_ta2"}, {31'd0, rbits[16]}, 32'd0);
      chk({tag, "_rdata"}, {16'd0, rbits[15:0]}, {16'd0, rd_model(v.ra)});
      chk({tag, "_oen_periods"}, oen_low_cnt, 17);
    end else begin
      chk({tag, "_oen_periods"}, oen_low_cnt, 0);
    end
    chk({tag, "_contention"}, {31'd0, contention}, 32'd0);
    $display("frame %s: kind=%0d op=%b phy=%0d reg=%0d oen_low=%0d", tag, v.kind, v.op, v.phy, v.ra, oen_low_cnt);
  endtask

  vec_t vt[13];

  initial begin
    vec_t        v;
    logic        s;
    logic [7:0]  hi;
    exp_t        e;
    logic        rd;

    vt[0]  = '{32, 2'b01, 2'b01, 5'd1, 5'd4,  2'b10, 16'hBEEF, K_W};
    vt[1]  = '{32, 2'b01, 2'b10, 5'd1, 5'd2,  2'b11, 16'h0000, K_R};
    vt[2]  = '{32, 2'b01, 2'b01, 5'd3, 5'd7,  2'b10, 16'h1111, K_NONE};
    vt[3]  = '{32, 2'b01, 2'b01, 5'd1, 5'd9,  2'b10, 16'h5A5A, K_W};
    vt[4]  = '{31, 2'b01, 2'b01, 5'd1, 5'd5,  2'b10, 16'h0F0F, K_NONE};
    vt[5]  = '{32, 2'b01, 2'b11, 5'd1, 5'd4,  2'b10, 16'h1234, K_E};
    vt[6]  = '{32, 2'b01, 2'b00, 5'd1, 5'd4,  2'b10, 16'h4321, K_E};
    vt[7]  = '{32, 2'b01, 2'b01, 5'd1, 5'd6,  2'b11, 16'h00FF, K_E};
    vt[8]  = '{32, 2'b01, 2'b10, 5'd2, 5'd8,  2'b11, 16'h0000, K_NONE};
    vt[9]  = '{32, 2'b01, 2'b10, 5'd1, 5'd31, 2'b11, 16'h0000, K_R};
    vt[10] = '{32, 2'b01, 2'b01, 5'd1, 5'd0,  2'b10, 16'h0000, K_W};
    vt[11] = '{40, 2'b01, 2'b01, 5'd1, 5'd31, 2'b10, 16'hFFFF, K_W};
    vt[12] = '{32, 2'b00, 2'b01, 5'd1, 5'd3,  2'b10, 16'hAAAA, K_E};

    // Reset state
    repeat (4) @(posedge clk);
    #1;
    chk("rst_oen", {31'd0, mdio_oen}, 32'd1);
    chk("rst_out", {31'd0, mdio_out}, 32'd0);
    chk("rst_rd_en", {31'd0, reg_rd_en}, 32'd0);
    chk("rst_wr_en", {31'd0, reg_wr_en}, 32'd0);
    chk("rst_err", {31'd0, frame_err}, 32'd0);
    chk("rst_addr", {27'd0, reg_addr}, 32'd0);
    chk("rst_wdata", {16'd0, reg_wr_data}, 32'd0);
    reset_n = 1'b1;
    @(posedge clk);

    // Table-driven frames
    for (int i = 0; i < 13; i++) frame(vt[i], $sformatf("vec%0d", i));

    // Reset during read data bit 8
    e.kind = K_R; e.addr = 5'd3; e.data = 16'h0;
    sb.push_back(e);
    for (int i = 0; i < 32; i++) mdc_bit(1'b1, 1'b0, s);
    send_bits(16'b01_10_00001_00011, 14);
    for (int i = 0; i < 2; i++) mdc_bit(1'b1, 1'b1, s);
    for (int i = 7; i >= 0; i--) begin
      mdc_bit(1'b1, 1'b1, s);
      hi[i] = s;
    end
    chk("rst_mid_hibyte", {24'd0, hi}, {24'd0, rd_model(5'd3) >> 8});
    chk("rst_mid_driving", {31'd0, mdio_oen}, 32'd0);
    @(posedge clk);
    #1 reset_n = 1'b0;
    @(posedge clk);
    #1;
    chk("rst_mid_oen", {31'd0, mdio_oen}, 32'd1);
    $display("reset mid-read: oen=%b", mdio_oen);
    reset_n = 1'b1;
    v = '{32, 2'b01, 2'b01, 5'd1, 5'd28, 2'b10, 16'hC0DE, K_W};
    frame(v, "post_rst");

    // Back-to-back frames with random MDC phase
    for (int k = 0; k < 6; k++) begin
      phase = $urandom_range(1, 9);
      rd    = 1'($urandom_range(0, 1));
      v = '{32, 2'b01, rd ? 2'b10 : 2'b01, 5'd1, 5'($urandom), 2'b10, 16'($urandom), rd ? K_R : K_W};
      frame(v, $sformatf("rand%0d", k));
    end

    mdc = 1'b0;
    m_en = 1'b0;
    repeat (40) @(posedge clk);
    chk("sb_empty", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete within time limit");
    $fatal(1, "timeout");
  end

endmodule
